// File: rtl/divisor_sub_desloca_pkg.sv
// Shared widths, iteration count and FSM encoding for the shift-subtract divider.
package divisor_sub_desloca_pkg;
  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int ACC_W      = 9;
  localparam int N_ITER     = 4;

  localparam logic [1:0] ITER_LAST = 2'(N_ITER - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/divisor_sub_desloca_acc_div.sv
// 9-bit accumulator for restoring division: load > shift(+subtract) > hold, one edge per step.
// No flow control; the controlling FSM decides every cycle what happens.
module acc_div
  import divisor_sub_desloca_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 sh,
  input  logic                 su,
  input  logic [ACC_W-1:0]     din,
  input  logic [DIVISOR_W-1:0] dvr,
  output logic [ACC_W-1:0]     acc,
  output logic                 fits
);

  logic [ACC_W-1:0]     t;
  logic [DIVISOR_W-1:0] diff;

  // The difference always fits in 4 bits when fits is true, so the low nibble
  // of t[7:4] - dvr is exact even if t[8] is set.
  always_comb begin
    t    = {acc[ACC_W-2:0], 1'b0};
    fits = (t[8:4] >= {1'b0, dvr});
    diff = t[7:4] - dvr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= din;
    end else if (sh) begin
      if (su) acc <= {1'b0, diff, t[3:1], 1'b1};
      else    acc <= t;
    end
  end

endmodule

// File: rtl/divisor_sub_desloca.sv
// 8/4 unsigned restoring divider: pronto 6 cycles after accept (2 on overflow).
// No backpressure; st is only honoured in IDLE, results hold until the next accept.
module divisor_sub_desloca
  import divisor_sub_desloca_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st,
  input  logic [DIVIDEND_W-1:0] dividendo,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [3:0]            quociente,
  output logic [3:0]            resto,
  output logic                  v,
  output logic                  pronto
);

  state_t               state, next_state;
  logic [1:0]           cnt;
  logic [DIVISOR_W-1:0] dvr;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     din;
  logic                 load, sh, su, fits, ovf;

  acc_div u_acc (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .sh   (sh),
    .su   (su),
    .din  (din),
    .dvr  (dvr),
    .acc  (acc),
    .fits (fits)
  );

  // Quotient cannot fit in 4 bits when the top nibble already reaches the divisor.
  assign ovf = (acc[7:4] >= dvr);
  assign su  = sh & fits;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    sh         = 1'b0;
    din        = '0;
    case (state)
      IDLE: begin
        if (st) begin
          load       = 1'b1;
          din        = {1'b0, dividendo};
          next_state = CHECK;
        end
      end
      CHECK: begin
        if (ovf) begin
          load       = 1'b1;
          next_state = DONE;
        end else begin
          next_state = ITER;
        end
      end
      ITER: begin
        sh = 1'b1;
        if (cnt == ITER_LAST) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dvr   <= '0;
      v     <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (st) begin
            dvr <= divisor;
            v   <= 1'b0;
          end
        end
        CHECK: begin
          if (ovf) v   <= 1'b1;
          else     cnt <= '0;
        end
        ITER:    cnt <= cnt + 2'd1;
        default: ;
      endcase
    end
  end

  assign quociente = acc[3:0];
  assign resto     = acc[7:4];
  assign pronto    = (state == DONE);

endmodule
